// File: rtl/match_controller_pkg.sv
// Shared types, widths and BCD helpers for the timed match controller.
package match_controller_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD2_W  = 2 * DIGIT_W;

    localparam int unsigned PRE_SEC_DEF = 3;
    localparam int unsigned GAME_T1_DEF = 6;
    localparam int unsigned GAME_T0_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_PLAY   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [BCD2_W-1:0] bcd_inc(input logic [BCD2_W-1:0] v);
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
        d1 = v[BCD2_W-1:DIGIT_W];
        d0 = v[DIGIT_W-1:0];
        if (d0 != 4'd9)      return {d1, d0 + 4'd1};
        else if (d1 != 4'd9) return {d1 + 4'd1, 4'd0};
        else                 return v;
    endfunction

    // Two-digit BCD decrement, saturating at 00.
    function automatic logic [BCD2_W-1:0] bcd_dec(input logic [BCD2_W-1:0] v);
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
        d1 = v[BCD2_W-1:DIGIT_W];
        d0 = v[DIGIT_W-1:0];
        if (d0 != 4'd0)      return {d1, d0 - 4'd1};
        else if (d1 != 4'd0) return {d1 - 4'd1, 4'd9};
        else                 return v;
    endfunction

endpackage

// File: rtl/match_controller_bcd2_counter.sv
// Two-digit BCD register: sync load, saturating inc/dec, async reset to RST_VAL.
module bcd2_counter
    import match_controller_pkg::*;
#(
    parameter int unsigned RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BCD2_W-1:0] load_val,
    input  logic              inc,
    input  logic              dec,
    output logic [BCD2_W-1:0] val
);

    logic [BCD2_W-1:0] val_q;
    logic [BCD2_W-1:0] val_d;

    // Load has priority over inc, inc over dec.
    always_comb begin
        val_d = val_q;
        if (load)     val_d = load_val;
        else if (inc) val_d = bcd_inc(val_q);
        else if (dec) val_d = bcd_dec(val_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) val_q <= BCD2_W'(RST_VAL);
        else     val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencer: IDLE -> PRE countdown -> timed PLAY -> FINISH, with score and best-score tracking.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int unsigned PRE_SEC = PRE_SEC_DEF,
    parameter int unsigned GAME_T1 = GAME_T1_DEF,
    parameter int unsigned GAME_T0 = GAME_T0_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               goal,
    output logic               tick_clr,
    output logic [1:0]         state,
    output logic [DIGIT_W-1:0] time_d1,
    output logic [DIGIT_W-1:0] time_d0,
    output logic [DIGIT_W-1:0] score_d1,
    output logic [DIGIT_W-1:0] score_d0,
    output logic [DIGIT_W-1:0] best_d1,
    output logic [DIGIT_W-1:0] best_d0,
    output logic               new_best
);

    localparam int unsigned      GAME_VAL = GAME_T1 * 16 + GAME_T0;
    localparam logic [BCD2_W-1:0] GAME_LD  = BCD2_W'(GAME_VAL);
    localparam logic [BCD2_W-1:0] PRE_LD   = BCD2_W'(PRE_SEC);

    state_e            state_q, state_d;
    logic [BCD2_W-1:0] best_q, best_d;
    logic              new_best_q, new_best_d;
    logic              tick_clr_q, tick_clr_d;

    logic [BCD2_W-1:0] time_val, score_val, score_fin, tmr_ld_val;
    logic              tmr_load, tmr_dec, scr_load, scr_inc, time_is_one;

    assign time_is_one = (time_val == BCD2_W'(1));
    // Score as it will stand after this edge, so a coincident goal counts toward best.
    assign score_fin   = goal ? bcd_inc(score_val) : score_val;

    always_comb begin
        state_d    = state_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        tick_clr_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_ld_val = GAME_LD;
        tmr_dec    = 1'b0;
        scr_load   = 1'b0;
        scr_inc    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d    = ST_PRE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = PRE_LD;
                    scr_load   = 1'b1;
                    new_best_d = 1'b0;
                    tick_clr_d = 1'b1;
                end
            end
            ST_PRE: begin
                if (tick) begin
                    if (time_is_one) begin
                        state_d  = ST_PLAY;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                scr_inc = goal;
                if (tick) begin
                    tmr_dec = 1'b1;
                    if (time_is_one) begin
                        state_d = ST_FINISH;
                        // Packed BCD compares correctly as plain binary.
                        if (score_fin > best_q) begin
                            best_d     = score_fin;
                            new_best_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            best_q     <= '0;
            new_best_q <= 1'b0;
            tick_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            tick_clr_q <= tick_clr_d;
        end
    end

    bcd2_counter #(.RST_VAL(GAME_VAL)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .inc      (1'b0),
        .dec      (tmr_dec),
        .val      (time_val)
    );

    bcd2_counter #(.RST_VAL(0)) u_score (
        .clk      (clk),
        .rst      (rst),
        .load     (scr_load),
        .load_val ('0),
        .inc      (scr_inc),
        .dec      (1'b0),
        .val      (score_val)
    );

    assign state    = state_q;
    assign tick_clr = tick_clr_q;
    assign new_best = new_best_q;
    assign time_d1  = time_val[BCD2_W-1:DIGIT_W];
    assign time_d0  = time_val[DIGIT_W-1:0];
    assign score_d1 = score_val[BCD2_W-1:DIGIT_W];
    assign score_d0 = score_val[DIGIT_W-1:0];
    assign best_d1  = best_q[BCD2_W-1:DIGIT_W];
    assign best_d0  = best_q[DIGIT_W-1:0];

endmodule
